// File: rtl/pipe_pkg.sv
// Shared types for the 5-stage MIPS pipeline control path.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Control fields carried by ID/EX; a bubble zeroes the whole bundle.
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] alu_op;
  } idex_ctrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator between the ID instruction and a load in EX.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [4:0] id_rs_addr,
  input  logic [4:0] id_rt_addr,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt_addr,
  output logic       load_use
);

  // $zero never carries a real dependency, and rt only matters when it is a source.
  always_comb begin
    load_use = ex_mem_read && (ex_rt_addr != REG_ZERO) &&
               ((ex_rt_addr == id_rs_addr) ||
                (id_uses_rt && (ex_rt_addr == id_rt_addr)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing: load-use stalls, branch flushes, data-memory waits and timeout.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs_addr,
  input  logic [4:0]       id_rt_addr,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt_addr,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             exmem_write,
  output logic             memwb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  hz_state_e        state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             load_use;

  hazard_detect u_hazard_detect (
    .id_rs_addr  (id_rs_addr),
    .id_rt_addr  (id_rt_addr),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rt_addr  (ex_rt_addr),
    .load_use    (load_use)
  );

  always_comb begin
    state_d      = state_q;
    wait_d       = '0;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_write  = 1'b1;
    memwb_bubble = 1'b0;
    mem_err      = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (mem_req && !dmem_ready) begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_write   = 1'b0;
          exmem_write  = 1'b0;
          memwb_bubble = 1'b1;
          state_d      = ST_MEM_WAIT;
        end else if (load_use) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end else if (branch_taken) begin
          ifid_flush = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_write   = 1'b0;
        exmem_write  = 1'b0;
        memwb_bubble = 1'b1;
        wait_d       = wait_q + 8'd1;
        // A ready on the timeout cycle still completes the access.
        if (dmem_ready) begin
          state_d = ST_RUN;
        end else if (wait_d == TIMEOUT) begin
          state_d = ST_ERROR;
        end
      end
      ST_ERROR: begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_write   = 1'b0;
        exmem_write  = 1'b0;
        memwb_bubble = 1'b1;
        mem_err      = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase

    stall_d = stall_q;
    if (!pc_write && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector scoreboard bench for pipe_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs_addr, id_rt_addr, ex_rt_addr;
  logic       id_uses_rt, ex_mem_read, branch_taken, mem_req, dmem_ready;
  logic       pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
  logic       exmem_write, memwb_bubble, mem_err;
  logic [3:0] stall_cnt;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs_addr   (id_rs_addr),
    .id_rt_addr   (id_rt_addr),
    .id_uses_rt   (id_uses_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_rt_addr   (ex_rt_addr),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .dmem_ready   (dmem_ready),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_write   (idex_write),
    .idex_bubble  (idex_bubble),
    .exmem_write  (exmem_write),
    .memwb_bubble (memwb_bubble),
    .mem_err      (mem_err),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, memwb_bubble, mem_err}
  localparam logic [7:0] NORM = 8'b1101_0100;
  localparam logic [7:0] LU   = 8'b0001_1100;
  localparam logic [7:0] BR   = 8'b1111_0100;
  localparam logic [7:0] FRZ  = 8'b0000_0010;
  localparam logic [7:0] ERR  = 8'b0000_0011;

  typedef struct {
    string      name;
    logic [7:0] ctrl;
    logic [3:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;

  // Monitor: outputs are combinational, so each pushed cycle is checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t       e;
      logic [7:0] act;
      e   = exp_q.pop_front();
      act = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
             exmem_write, memwb_bubble, mem_err};
      tests++;
      if (act !== e.ctrl || stall_cnt !== e.cnt) begin
        failed++;
        $display("FAIL %s: ctrl=%b cnt=%0d, expected ctrl=%b cnt=%0d",
                 e.name, act, stall_cnt, e.ctrl, e.cnt);
      end
    end
  end

  task automatic step(input string n, input logic [4:0] rs, input logic [4:0] rt,
                      input logic uses, input logic mr, input logic [4:0] ert,
                      input logic br, input logic mreq, input logic rdy,
                      input logic [7:0] ec, input logic [3:0] cnt);
    exp_t e;
    id_rs_addr = rs; id_rt_addr = rt; id_uses_rt = uses;
    ex_mem_read = mr; ex_rt_addr = ert; branch_taken = br;
    mem_req = mreq; dmem_ready = rdy;
    e.name = n; e.ctrl = ec; e.cnt = cnt;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input string n, input logic [7:0] ec, input logic [3:0] cnt);
    step(n, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ec, cnt);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    id_rs_addr = '0; id_rt_addr = '0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
    ex_rt_addr = '0; branch_taken = 1'b0; mem_req = 1'b0; dmem_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    idle("reset_state", NORM, 4'd0);

    // Load-use on rs, then bubble clears ex_mem_read.
    step("lu_rs", 5'd8, 5'd3, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, LU, 4'd0);
    step("lu_after", 5'd8, 5'd3, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, NORM, 4'd1);
    // $zero and rt-use filters.
    step("zero_reg", 5'd0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, NORM, 4'd1);
    step("rt_unused", 5'd1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, NORM, 4'd1);
    step("rt_used", 5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, LU, 4'd1);
    // Branch suppressed under load-use, taken on re-presentation.
    step("br_under_lu", 5'd8, 5'd3, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, LU, 4'd2);
    step("br_retry", 5'd8, 5'd3, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, BR, 4'd3);
    step("memreq_ready", 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, NORM, 4'd3);

    // Memory wait: ready low for 3 cycles then high -> 4 freeze cycles.
    do_reset();
    step("mw_start", 5'd8, 5'd3, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, FRZ, 4'd0);
    step("mw_1", 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, FRZ, 4'd1);
    step("mw_2", 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ, 4'd2);
    step("mw_ready", 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, FRZ, 4'd3);
    idle("mw_back_run", NORM, 4'd4);

    // Timeout on the 4th MEM_WAIT cycle.
    do_reset();
    step("to_start", 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ, 4'd0);
    for (int unsigned i = 1; i <= 4; i++)
      step("to_wait", 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ, 4'(i));
    idle("to_error", ERR, 4'd5);
    step("to_err_hold", 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, ERR, 4'd6);
    do_reset();
    idle("to_reset", NORM, 4'd0);

    // Tie: ready on exactly the 4th MEM_WAIT cycle.
    do_reset();
    step("tie_start", 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ, 4'd0);
    for (int unsigned i = 1; i <= 3; i++)
      step("tie_wait", 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ, 4'(i));
    step("tie_ready", 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, FRZ, 4'd4);
    idle("tie_run", NORM, 4'd5);

    // Saturation: 20 consecutive stall cycles with a 4-bit counter.
    do_reset();
    for (int unsigned i = 0; i < 20; i++)
      step("sat_stall", 5'd8, 5'd3, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, LU,
           (i > 15) ? 4'd15 : 4'(i));
    idle("sat_final", NORM, 4'd15);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      tests++;
      failed++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
